// File: rtl/vscale_hasti_arbiter.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter
// Shares one single-port HASTI (AHB-lite) slave between two masters.
// Arbitration is combinational at every address-phase boundary (s_hready=1).
// p0 (dmem) normally wins. p1 (imem) wins once it has lost MAX_WAIT boundaries
// in a row. When a master's data phase completes but its next address phase
// lost arbitration, the read data/response is buffered and handed back to the
// master later, on the boundary where its pending address phase is accepted.
//
// Ports
//   clk, reset              clock, async active-high reset
//   p0_* / p1_*             master-side AHB-lite: address phase + hwdata in,
//                           hrdata/hready/hresp out
//   s_*                     slave-side AHB-lite: address phase + hwdata out,
//                           hrdata/hready/hresp in
//
// Data-phase owner (owner_q)
//   state    | meaning
//   SEL_NONE | no data phase in flight (idle or nothing accepted)
//   SEL_P0   | slave data phase belongs to p0
//   SEL_P1   | slave data phase belongs to p1
// -----------------------------------------------------------------------------
module vscale_hasti_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] p0_haddr,
   input  logic        p0_hwrite,
   input  logic [2:0]  p0_hsize,
   input  logic [2:0]  p0_hburst,
   input  logic        p0_hmastlock,
   input  logic [3:0]  p0_hprot,
   input  logic [1:0]  p0_htrans,
   input  logic [31:0] p0_hwdata,
   output logic [31:0] p0_hrdata,
   output logic        p0_hready,
   output logic        p0_hresp,
   input  logic [31:0] p1_haddr,
   input  logic        p1_hwrite,
   input  logic [2:0]  p1_hsize,
   input  logic [2:0]  p1_hburst,
   input  logic        p1_hmastlock,
   input  logic [3:0]  p1_hprot,
   input  logic [1:0]  p1_htrans,
   input  logic [31:0] p1_hwdata,
   output logic [31:0] p1_hrdata,
   output logic        p1_hready,
   output logic        p1_hresp,
   output logic [31:0] s_haddr,
   output logic        s_hwrite,
   output logic [2:0]  s_hsize,
   output logic [2:0]  s_hburst,
   output logic        s_hmastlock,
   output logic [3:0]  s_hprot,
   output logic [1:0]  s_htrans,
   output logic [31:0] s_hwdata,
   input  logic [31:0] s_hrdata,
   input  logic        s_hready,
   input  logic        s_hresp
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

   typedef struct packed {
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [2:0]  hburst;
      logic        hmastlock;
      logic [3:0]  hprot;
      logic [1:0]  htrans;
   } addr_phase_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_P0   = 2'd1,
      SEL_P1   = 2'd2
   } sel_e;

   addr_phase_t      p0_ap, p1_ap, s_ap, hold_q, hold_d;
   sel_e             addr_sel, owner_q, owner_d;
   logic [CW-1:0]    wait_q, wait_d;
   logic [1:0]       req, granted, owns;
   logic [1:0]       done_q, done_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [1:0][31:0] rbuf_q, rbuf_d;
   logic [1:0]       hready_m, hresp_m;
   logic [1:0][31:0] hrdata_m;

   assign p0_ap = {p0_haddr, p0_hwrite, p0_hsize, p0_hburst, p0_hmastlock, p0_hprot, p0_htrans};
   assign p1_ap = {p1_haddr, p1_hwrite, p1_hsize, p1_hburst, p1_hmastlock, p1_hprot, p1_htrans};

   // htrans[1] covers both NONSEQ and SEQ
   assign req     = {p1_htrans[1], p0_htrans[1]};
   assign granted = {addr_sel == SEL_P1, addr_sel == SEL_P0};
   assign owns    = {owner_q == SEL_P1, owner_q == SEL_P0};

   // Arbitration only happens on a boundary; reset forces NONE so no slave
   // transfer can start while the block is held in reset.
   always_comb begin
      addr_sel = SEL_NONE;
      if (!reset && s_hready) begin
         if (req[1] && (!req[0] || wait_q == WAIT_LIMIT)) begin
            addr_sel = SEL_P1;
         end else if (req[0]) begin
            addr_sel = SEL_P0;
         end
      end
   end

   // During slave wait states the last accepted address phase is replayed
   // from the hold register so the slave-side bus stays stable.
   always_comb begin
      s_ap = '0;
      if (reset) begin
         s_ap = '0;
      end else if (!s_hready) begin
         s_ap = hold_q;
      end else if (addr_sel == SEL_P0) begin
         s_ap = p0_ap;
      end else if (addr_sel == SEL_P1) begin
         s_ap = p1_ap;
      end
   end

   assign s_haddr     = s_ap.haddr;
   assign s_hwrite    = s_ap.hwrite;
   assign s_hsize     = s_ap.hsize;
   assign s_hburst    = s_ap.hburst;
   assign s_hmastlock = s_ap.hmastlock;
   assign s_hprot     = s_ap.hprot;
   assign s_htrans    = s_ap.htrans;

   always_comb begin
      s_hwdata = '0;
      case (owner_q)
         SEL_P0:  s_hwdata = p0_hwdata;
         SEL_P1:  s_hwdata = p1_hwdata;
         default: s_hwdata = '0;
      endcase
   end

   assign hold_d  = s_hready ? s_ap : hold_q;
   assign owner_d = s_hready ? addr_sel : owner_q;

   always_comb begin
      wait_d = wait_q;
      if (s_hready) begin
         if (addr_sel == SEL_P1) begin
            wait_d = '0;
         end else if (req[1] && wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   // Per-master response path. A finished data phase whose master cannot yet
   // be released (its next address lost arbitration) is parked in rbuf and
   // returned on the boundary where that master's address is accepted.
   always_comb begin
      logic rdy;
      rdy      = 1'b1;
      hready_m = '1;
      hresp_m  = '0;
      hrdata_m = '0;
      done_d   = done_q;
      rbuf_d   = rbuf_q;
      rresp_d  = rresp_q;
      for (int i = 0; i < 2; i++) begin
         rdy = 1'b1;
         if (reset) begin
            rdy = 1'b1;
         end else if (done_q[i]) begin
            rdy         = s_hready && granted[i];
            hrdata_m[i] = rbuf_q[i];
            hresp_m[i]  = rresp_q[i];
            if (rdy) begin
               done_d[i] = 1'b0;
            end
         end else if (owns[i]) begin
            rdy         = s_hready && (!req[i] || granted[i]);
            hrdata_m[i] = s_hrdata;
            hresp_m[i]  = s_hresp;
            if (s_hready && !rdy) begin
               done_d[i]  = 1'b1;
               rbuf_d[i]  = s_hrdata;
               rresp_d[i] = s_hresp;
            end
         end else begin
            rdy = !req[i] || (s_hready && granted[i]);
         end
         hready_m[i] = rdy;
      end
   end

   assign p0_hready = hready_m[0];
   assign p0_hrdata = hrdata_m[0];
   assign p0_hresp  = hresp_m[0];
   assign p1_hready = hready_m[1];
   assign p1_hrdata = hrdata_m[1];
   assign p1_hresp  = hresp_m[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= SEL_NONE;
         wait_q  <= '0;
         hold_q  <= '0;
         done_q  <= '0;
         rbuf_q  <= '0;
         rresp_q <= '0;
      end else begin
         owner_q <= owner_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         rbuf_q  <= rbuf_d;
         rresp_q <= rresp_d;
      end
   end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_vscale_hasti_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk, reset;
   logic [31:0] p0_haddr, p0_hwdata, p0_hrdata;
   logic        p0_hwrite, p0_hmastlock, p0_hready, p0_hresp;
   logic [2:0]  p0_hsize, p0_hburst;
   logic [3:0]  p0_hprot;
   logic [1:0]  p0_htrans;
   logic [31:0] p1_haddr, p1_hwdata, p1_hrdata;
   logic        p1_hwrite, p1_hmastlock, p1_hready, p1_hresp;
   logic [2:0]  p1_hsize, p1_hburst;
   logic [3:0]  p1_hprot;
   logic [1:0]  p1_htrans;
   logic [31:0] s_haddr, s_hwdata, s_hrdata;
   logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
   logic [2:0]  s_hsize, s_hburst;
   logic [3:0]  s_hprot;
   logic [1:0]  s_htrans;

   int n_tests = 0;
   int n_fail  = 0;

   vscale_hasti_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .p0_haddr(p0_haddr), .p0_hwrite(p0_hwrite), .p0_hsize(p0_hsize), .p0_hburst(p0_hburst),
      .p0_hmastlock(p0_hmastlock), .p0_hprot(p0_hprot), .p0_htrans(p0_htrans), .p0_hwdata(p0_hwdata),
      .p0_hrdata(p0_hrdata), .p0_hready(p0_hready), .p0_hresp(p0_hresp),
      .p1_haddr(p1_haddr), .p1_hwrite(p1_hwrite), .p1_hsize(p1_hsize), .p1_hburst(p1_hburst),
      .p1_hmastlock(p1_hmastlock), .p1_hprot(p1_hprot), .p1_htrans(p1_htrans), .p1_hwdata(p1_hwdata),
      .p1_hrdata(p1_hrdata), .p1_hready(p1_hready), .p1_hresp(p1_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
      .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge, outputs are sampled at +5
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic r, input logic [1:0] t0, input logic [31:0] a0,
                        input logic w0, input logic [31:0] wd0, input logic [1:0] t1,
                        input logic [31:0] a1, input logic sr, input logic [31:0] srd,
                        input logic srs);
      reset = r;
      p0_htrans = t0; p0_haddr = a0; p0_hwrite = w0; p0_hwdata = wd0;
      p0_hsize = 3'd2; p0_hburst = 3'd0; p0_hmastlock = 1'b0; p0_hprot = 4'h3;
      p1_htrans = t1; p1_haddr = a1; p1_hwrite = 1'b0; p1_hwdata = 32'h0;
      p1_hsize = 3'd2; p1_hburst = 3'd0; p1_hmastlock = 1'b0; p1_hprot = 4'h2;
      s_hready = sr; s_hrdata = srd; s_hresp = srs;
   endtask

   task automatic do_reset();
      apply(1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b0);
      step();
      reset = 1'b0;
   endtask

   // ---------------- reference model ----------------
   int          m_owner;        // -1 none, 0 = p0, 1 = p1
   bit          m_pend[2];      // response parked for master
   logic [31:0] m_pdata[2];
   logic        m_presp[2];
   int          m_lost;         // consecutive boundaries p1 asked and lost
   logic [45:0] m_held;         // slave-side address phase shown during waits

   task automatic model_reset();
      m_owner = -1; m_pend[0] = 0; m_pend[1] = 0; m_pdata[0] = 0; m_pdata[1] = 0;
      m_presp[0] = 0; m_presp[1] = 0; m_lost = 0; m_held = '0;
   endtask

   task automatic model_cycle();
      logic [45:0] ap[2];
      logic [45:0] e_ap, s_ap;
      logic [31:0] e_wd, e_rd[2];
      logic        e_rs[2];
      bit          rq[2], e_rdy[2];
      int          win;
      ap[0] = {p0_haddr, p0_hwrite, p0_hsize, p0_hburst, p0_hmastlock, p0_hprot, p0_htrans};
      ap[1] = {p1_haddr, p1_hwrite, p1_hsize, p1_hburst, p1_hmastlock, p1_hprot, p1_htrans};
      s_ap  = {s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans};
      rq[0] = p0_htrans[1];
      rq[1] = p1_htrans[1];
      win = -1;
      if (reset) begin
         e_ap = '0; e_wd = '0;
         for (int i = 0; i < 2; i++) begin e_rdy[i] = 1; e_rd[i] = '0; e_rs[i] = 0; end
      end else begin
         if (s_hready) begin
            if (rq[1] && (!rq[0] || m_lost >= MAX_WAIT)) win = 1;
            else if (rq[0]) win = 0;
         end
         e_ap = !s_hready ? m_held : (win >= 0 ? ap[win] : '0);
         e_wd = (m_owner == 0) ? p0_hwdata : (m_owner == 1) ? p1_hwdata : 32'h0;
         for (int i = 0; i < 2; i++) begin
            e_rd[i] = '0; e_rs[i] = 0;
            if (m_pend[i]) begin
               e_rdy[i] = s_hready && (win == i);
               e_rd[i] = m_pdata[i]; e_rs[i] = m_presp[i];
            end else if (m_owner == i) begin
               e_rdy[i] = s_hready && (!rq[i] || win == i);
               e_rd[i] = s_hrdata; e_rs[i] = s_hresp;
            end else begin
               e_rdy[i] = !rq[i] || (s_hready && win == i);
            end
         end
      end
      chk("rand s_addr_phase", s_ap, e_ap);
      chk("rand s_hwdata", s_hwdata, e_wd);
      chk("rand p0_hready", p0_hready, e_rdy[0]);
      chk("rand p1_hready", p1_hready, e_rdy[1]);
      chk("rand p0_hrdata", p0_hrdata, e_rd[0]);
      chk("rand p1_hrdata", p1_hrdata, e_rd[1]);
      chk("rand p0_hresp", p0_hresp, e_rs[0]);
      chk("rand p1_hresp", p1_hresp, e_rs[1]);
      if (reset) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) begin
               if (e_rdy[i]) m_pend[i] = 0;
            end else if (m_owner == i && s_hready && !e_rdy[i]) begin
               m_pend[i] = 1; m_pdata[i] = s_hrdata; m_presp[i] = s_hresp;
            end
         end
         if (s_hready) begin
            m_owner = win;
            m_held  = e_ap;
            if (win == 1) m_lost = 0;
            else if (rq[1]) m_lost = (m_lost + 1 > MAX_WAIT) ? MAX_WAIT : m_lost + 1;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic [1:0]  p0_trans;
      logic [31:0] p0_addr;
      logic        p0_write;
      logic [31:0] p0_wdata;
      logic [1:0]  p1_trans;
      logic [31:0] p1_addr;
      logic        s_rdy;
      logic [31:0] s_rdata;
      logic        s_resp;
      logic [1:0]  e_trans;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_rdy0, e_rdy1;
      logic [31:0] e_rd0, e_rd1;
      logic        e_rs0, e_rs1;
   } vec_t;

   vec_t vecs[8];

   initial begin
      // reset with both masters requesting, then one idle cycle after reset
      vecs[0] = '{1'b1, 2'd2, 32'h10, 1'b0, 32'h0, 2'd2, 32'h20, 1'b1, 32'hAAAA5555, 1'b1,
                  2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[1] = vecs[0];
      vecs[2] = '{1'b0, 2'd0, 32'h10, 1'b0, 32'h0, 2'd0, 32'h20, 1'b1, 32'hAAAA5555, 1'b1,
                  2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
      // uncontended p1 read
      vecs[3] = '{1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd2, 32'h100, 1'b1, 32'h0, 1'b0,
                  2'd2, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0,
                  2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
      // contention: p0 write 0x200 vs p1 read 0x300
      vecs[5] = '{1'b0, 2'd2, 32'h200, 1'b1, 32'h0BADBAD0, 2'd2, 32'h300, 1'b1, 32'h0, 1'b0,
                  2'd2, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 2'd0, 32'h0, 1'b0, 32'h12345678, 2'd2, 32'h300, 1'b1, 32'h0, 1'b0,
                  2'd2, 32'h300, 32'h12345678, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0F0F0F0F, 1'b1,
                  2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b1};

      apply(1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b0);
      #1;
      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].rst, vecs[i].p0_trans, vecs[i].p0_addr, vecs[i].p0_write, vecs[i].p0_wdata,
               vecs[i].p1_trans, vecs[i].p1_addr, vecs[i].s_rdy, vecs[i].s_rdata, vecs[i].s_resp);
         #4;
         chk($sformatf("vec%0d s_htrans", i), s_htrans, vecs[i].e_trans);
         chk($sformatf("vec%0d s_haddr", i), s_haddr, vecs[i].e_addr);
         chk($sformatf("vec%0d s_hwdata", i), s_hwdata, vecs[i].e_wdata);
         chk($sformatf("vec%0d p0_hready", i), p0_hready, vecs[i].e_rdy0);
         chk($sformatf("vec%0d p1_hready", i), p1_hready, vecs[i].e_rdy1);
         chk($sformatf("vec%0d p0_hrdata", i), p0_hrdata, vecs[i].e_rd0);
         chk($sformatf("vec%0d p1_hrdata", i), p1_hrdata, vecs[i].e_rd1);
         chk($sformatf("vec%0d p0_hresp", i), p0_hresp, vecs[i].e_rs0);
         chk($sformatf("vec%0d p1_hresp", i), p1_hresp, vecs[i].e_rs1);
         step();
      end

      // starvation: p1 wins exactly on boundaries 5 and 10 (counter cleared after 5)
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         apply(1'b0, 2'd2, 32'hA0, 1'b0, 32'h0, 2'd2, 32'hB0, 1'b1, 32'h0, 1'b0);
         #4;
         chk($sformatf("starve%0d s_haddr", k), s_haddr, (k == 5 || k == 10) ? 32'hB0 : 32'hA0);
         chk($sformatf("starve%0d p1_hready", k), p1_hready, (k == 5 || k == 10) ? 1'b1 : 1'b0);
         step();
      end

      // buffered completion of p0's read of 0x400
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         apply(1'b0, 2'd2, (k == 4) ? 32'h400 : 32'h3F0, 1'b0, 32'h0, 2'd2, 32'h500, 1'b1, 32'h0, 1'b0);
         #4;
         chk($sformatf("buf%0d s_haddr", k), s_haddr, (k == 4) ? 32'h400 : 32'h3F0);
         step();
      end
      apply(1'b0, 2'd2, 32'h404, 1'b0, 32'h0, 2'd2, 32'h500, 1'b1, 32'hCAFEF00D, 1'b0);
      #4;
      chk("buf5 s_haddr", s_haddr, 32'h500);
      chk("buf5 p0_hready", p0_hready, 1'b0);
      chk("buf5 p0_hrdata", p0_hrdata, 32'hCAFEF00D);
      step();
      apply(1'b0, 2'd2, 32'h404, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h11111111, 1'b0);
      #4;
      chk("buf6 s_haddr", s_haddr, 32'h404);
      chk("buf6 p0_hready", p0_hready, 1'b1);
      chk("buf6 p0_hrdata", p0_hrdata, 32'hCAFEF00D);
      chk("buf6 p1_hready", p1_hready, 1'b1);
      chk("buf6 p1_hrdata", p1_hrdata, 32'h11111111);
      step();

      // slave wait states in the middle of p0's write to 0x600
      do_reset();
      apply(1'b0, 2'd2, 32'h600, 1'b1, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b0);
      #4;
      chk("ws1 s_haddr", s_haddr, 32'h600);
      chk("ws1 p0_hready", p0_hready, 1'b1);
      step();
      for (int k = 2; k <= 4; k++) begin
         apply(1'b0, 2'd2, 32'h604, 1'b0, 32'h600D, 2'd2, 32'h700, 1'b0, 32'h77, 1'b0);
         #4;
         chk($sformatf("ws%0d s_haddr", k), s_haddr, 32'h600);
         chk($sformatf("ws%0d s_htrans", k), s_htrans, 2'd2);
         chk($sformatf("ws%0d s_hwrite", k), s_hwrite, 1'b1);
         chk($sformatf("ws%0d s_hwdata", k), s_hwdata, 32'h600D);
         chk($sformatf("ws%0d p0_hready", k), p0_hready, 1'b0);
         chk($sformatf("ws%0d p1_hready", k), p1_hready, 1'b0);
         chk($sformatf("ws%0d p0_hrdata", k), p0_hrdata, 32'h77);
         step();
      end
      apply(1'b0, 2'd2, 32'h604, 1'b0, 32'h600D, 2'd2, 32'h700, 1'b1, 32'h99, 1'b0);
      #4;
      chk("ws5 s_haddr", s_haddr, 32'h604);
      chk("ws5 p0_hready", p0_hready, 1'b1);
      chk("ws5 p1_hready", p1_hready, 1'b0);
      chk("ws5 p0_hrdata", p0_hrdata, 32'h99);
      step();

      // randomized traffic, including occasional mid-operation resets
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         p0_htrans = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         p1_htrans = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         p0_haddr = $urandom; p0_hwrite = 1'($urandom_range(0, 1)); p0_hsize = 3'($urandom_range(0, 7));
         p0_hburst = 3'($urandom_range(0, 7)); p0_hmastlock = 1'($urandom_range(0, 1));
         p0_hprot = 4'($urandom_range(0, 15)); p0_hwdata = $urandom;
         p1_haddr = $urandom; p1_hwrite = 1'($urandom_range(0, 1)); p1_hsize = 3'($urandom_range(0, 7));
         p1_hburst = 3'($urandom_range(0, 7)); p1_hmastlock = 1'($urandom_range(0, 1));
         p1_hprot = 4'($urandom_range(0, 15)); p1_hwdata = $urandom;
         s_hready = ($urandom_range(0, 3) != 0);
         s_hrdata = $urandom;
         s_hresp  = 1'($urandom_range(0, 1));
         #4;
         model_cycle();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
